hpi_responder: RTL and testbench
================================

# hpi_responder

Device-side responder for the 16-bit HPI port that our host interface drives. It decodes the OTG_ADDR, OTG_CS_N, OTG_RD_N and OTG_WR_N strobes, serves four HPI registers (DATA, MAILBOX, ADDRESS, STATUS) from an internal word RAM, and exposes a local port and mailbox to device-side logic. It sits opposite the host interface on the same bus, in-system or in the bench, on the shared Clk.

## Interface
- ADDR_W, 8: word-address width; the RAM holds 2^ADDR_W 16-bit words.
- MBX_RST, 16'h0000: reset value of both mailbox registers.

- Clk  in  1  system clock; all logic is on the rising edge.
- Reset_N  in  1  reset, asynchronous, active-low.
- OTG_DATA  inout  16  HPI data bus; high-Z unless this block is driving a read.
- OTG_ADDR  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- OTG_CS_N, OTG_RD_N, OTG_WR_N  in  1 each  active-low bus strobes.
- OTG_INT  out  1  high while the device-to-host mailbox is full.
- loc_addr  in  ADDR_W  local word address.
- loc_req, loc_we  in  1 each  local request; loc_we=1 selects write.
- loc_wdata  in  16  local write data.
- loc_ack  out  1  one-cycle pulse when the local request is accepted.
- loc_rdata  out  16  local read data, valid with loc_ack.
- mbx_in  out  16  last host MAILBOX write.
- mbx_in_vld  out  1  host mailbox full; cleared by mbx_in_pop.
- mbx_in_pop  in  1  device consumes mbx_in.
- mbx_out_data  in  16  device-to-host mailbox value.
- mbx_out_push  in  1  loads mbx_out_data and sets the out-full flag.

## Operation
- Strobes are sampled on Clk, and the block keeps registered copies of their previous values.
- Write event: cycle with CS_N=0, WR_N=0 and previous WR_N=1. Bus data and address are captured in that cycle.
- Read start: cycle with CS_N=0, RD_N=0 and previous RD_N=1.
- Read end: first cycle with RD_N=1 after a read started.
- FSM states:
  - IDLE: read start goes to RD; write event goes to WR.
  - RD: stay while RD_N=0 and CS_N=0. On read end or CS_N=1, go to IDLE and perform the DATA post-increment.
  - WR: return to IDLE once WR_N=1.
- Register actions:
  - ADDRESS write: ptr ← data[ADDR_W:1]. Byte address; bit 0 and bits above ADDR_W are ignored.
  - ADDRESS read: returns {ptr, 1'b0} zero-extended to 16 bits.
  - DATA write: ram[ptr] ← data, then ptr increments.
  - DATA read: returns ram[ptr]; ptr increments at read end.
  - MAILBOX write: mbx_in ← data and mbx_in_vld ← 1. A write while full overwrites the value and vld stays 1.
  - MAILBOX read: returns mbx_out and clears out-full. Clearing happens at read end.
  - STATUS read: {14'b0, out_full, mbx_in_vld}. STATUS writes are ignored.
- ptr increment wraps from 2^ADDR_W−1 to 0.
- Local port: a request is accepted in any cycle in which the HPI side is not doing a RAM access, that is, no write event to DATA and no read start on DATA.
  - Accepted request: loc_ack=1 in the next cycle, and loc_rdata is valid in that same cycle.
  - Otherwise the request waits, and loc_req must be held until loc_ack.
- Simultaneous events:
  - mbx_out_push in the same cycle as a MAILBOX read end: push wins, out-full stays 1, and the new value is loaded.
  - mbx_in_pop in the same cycle as a MAILBOX write: write wins, vld stays 1.
- Reset asserted mid-access: OTG_DATA goes high-Z immediately, the FSM returns to IDLE, and the RAM contents are not cleared.

## Timing
- Reset values:
  - OTG_DATA high-Z; OTG_INT 0.
  - loc_ack 0; loc_rdata 0.
  - mbx_in MBX_RST; mbx_in_vld 0; internal mbx_out MBX_RST; out-full 0.
  - ptr 0; FSM IDLE.
- Read latency:
  - Read start in cycle N: OTG_DATA drives valid data from cycle N+1, from a registered value and a registered enable.
  - The bus returns to high-Z in the cycle after read end.
- Write: the register or RAM update is visible in the cycle after the write event.
- OTG_INT equals out-full, registered; it rises the cycle after mbx_out_push.
- Back-to-back DATA reads need RD_N high for at least 1 cycle between reads, giving 1 word every 2 cycles minimum.

## Configuration
- HPI_AUTOINC_EN:
  - Defined: DATA reads and writes post-increment ptr as above.
  - Undefined: ptr changes only on ADDRESS writes, and repeated DATA accesses hit the same word.

## Test plan
- Reset_N low mid-read of DATA → OTG_DATA high-Z immediately; STATUS reads 16'h0000 after release.
- Write ADDRESS=16'h0010, then DATA 16'hA5A5 and 16'h5A5A; local reads of words 8 and 9 → 16'hA5A5 and 16'h5A5A; ADDRESS read returns 16'h0014.
- ADDRESS=2^(ADDR_W+1)−2, then two DATA writes → the second write lands in word 0. With HPI_AUTOINC_EN undefined, both writes hit the same word.
- Host MAILBOX write 16'h1234 → mbx_in=16'h1234, mbx_in_vld=1, STATUS=16'h0001; after mbx_in_pop, STATUS=16'h0000.
- mbx_out_push 16'hBEEF → OTG_INT=1 next cycle; host MAILBOX read returns 16'hBEEF, and OTG_INT=0 after read end. Push coincident with read end keeps OTG_INT=1.
- loc_req held during a DATA write event → loc_ack delayed one cycle; no data corrupted.

Source files
------------

// File: rtl/hpi_responder_if.sv
// Device-side port bundle for hpi_responder: the local RAM request/ack
// handshake and the two mailbox channels between the responder and the
// device logic. The HPI pad pins themselves stay plain ports on the responder.
interface hpi_responder_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] loc_addr;
  logic              loc_req;
  logic              loc_we;
  logic [15:0]       loc_wdata;
  logic              loc_ack;
  logic [15:0]       loc_rdata;
  logic [15:0]       mbx_in;
  logic              mbx_in_vld;
  logic              mbx_in_pop;
  logic [15:0]       mbx_out_data;
  logic              mbx_out_push;

  // Device logic side
  modport master (
    output loc_addr, loc_req, loc_we, loc_wdata, mbx_in_pop, mbx_out_data, mbx_out_push,
    input  loc_ack, loc_rdata, mbx_in, mbx_in_vld
  );

  // Responder side
  modport slave (
    input  loc_addr, loc_req, loc_we, loc_wdata, mbx_in_pop, mbx_out_data, mbx_out_push,
    output loc_ack, loc_rdata, mbx_in, mbx_in_vld
  );
endinterface

// File: rtl/hpi_responder.sv
// hpi_responder: device-side responder for the 16-bit HPI bus.
// Decodes the host strobes, serves DATA/MAILBOX/ADDRESS/STATUS from a word RAM
// and mailbox registers, and shares the RAM with a local request/ack port.
// Optional feature macro: HPI_AUTOINC_EN -- when defined, DATA reads and writes
// post-increment the word pointer; when undefined the pointer only moves on
// ADDRESS writes.
module hpi_responder #(
  parameter int          ADDR_W  = 8,
  parameter logic [15:0] MBX_RST = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset_N,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  output logic        OTG_INT,
  hpi_responder_if.slave dev
);

`ifdef HPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_t;

  state_t            r_state;
  logic              r_rd_n_prev;
  logic              r_wr_n_prev;
  logic [ADDR_W-1:0] r_ptr;
  logic [1:0]        r_rd_sel;
  logic              r_oe;
  logic [15:0]       r_dout;
  logic [15:0]       r_mbx_in;
  logic              r_mbx_in_vld;
  logic [15:0]       r_mbx_out;
  logic              r_out_full;
  logic              r_loc_ack;

  logic [15:0]       r_ram [2**ADDR_W];
  logic [15:0]       r_hpi_q;
  logic [15:0]       r_loc_q;

  logic              w_idle;
  logic              w_rd_start;
  logic              w_wr_evt;
  logic              w_rd_end;
  logic              w_hpi_ram_wr;
  logic              w_hpi_ram_rd;
  logic              w_loc_acc;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [15:0]       w_ram_wdata;
  logic [ADDR_W-1:0] w_ptr_inc;

  // Edge detection uses the previous strobe levels; a read start takes
  // priority if both strobes fall together.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_rd_start   = w_idle && !OTG_CS_N && !OTG_RD_N && r_rd_n_prev;
  assign w_wr_evt     = w_idle && !OTG_CS_N && !OTG_WR_N && r_wr_n_prev && !w_rd_start;
  assign w_rd_end     = (r_state == ST_RD) && (OTG_RD_N || OTG_CS_N);
  assign w_hpi_ram_wr = w_wr_evt && (OTG_ADDR == REG_DATA);
  assign w_hpi_ram_rd = w_rd_start && (OTG_ADDR == REG_DATA);
  assign w_ptr_inc    = r_ptr + ADDR_W'(1);

  // The local port only gets the RAM in cycles the host is not using it.
  assign w_loc_acc    = dev.loc_req && !w_hpi_ram_wr && !w_hpi_ram_rd;
  assign w_ram_we     = w_hpi_ram_wr || (w_loc_acc && dev.loc_we);
  assign w_ram_waddr  = w_hpi_ram_wr ? r_ptr : dev.loc_addr;
  assign w_ram_wdata  = w_hpi_ram_wr ? OTG_DATA : dev.loc_wdata;

  // Word RAM with registered read ports; no reset so contents survive Reset_N.
  always_ff @(posedge Clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_waddr] <= w_ram_wdata;
    end
    if (w_hpi_ram_rd) begin
      r_hpi_q <= r_ram[r_ptr];
    end
    if (w_loc_acc) begin
      r_loc_q <= r_ram[dev.loc_addr];
    end
  end

  // Bus FSM, pointer, mailboxes and all registered outputs.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state      <= ST_IDLE;
      r_rd_n_prev  <= 1'b1;
      r_wr_n_prev  <= 1'b1;
      r_ptr        <= '0;
      r_rd_sel     <= REG_DATA;
      r_oe         <= 1'b0;
      r_dout       <= 16'h0000;
      r_mbx_in     <= MBX_RST;
      r_mbx_in_vld <= 1'b0;
      r_mbx_out    <= MBX_RST;
      r_out_full   <= 1'b0;
      r_loc_ack    <= 1'b0;
    end else begin
      r_rd_n_prev <= OTG_RD_N;
      r_wr_n_prev <= OTG_WR_N;
      r_loc_ack   <= w_loc_acc;

      case (r_state)
        ST_IDLE: begin
          if (w_rd_start) begin
            r_state  <= ST_RD;
            r_oe     <= 1'b1;
            r_rd_sel <= OTG_ADDR;
            case (OTG_ADDR)
              REG_MBX:  r_dout <= r_mbx_out;
              REG_ADDR: r_dout <= 16'({r_ptr, 1'b0});
              REG_STAT: r_dout <= {14'b0, r_out_full, r_mbx_in_vld};
              default:  r_dout <= r_dout;
            endcase
          end else if (w_wr_evt) begin
            r_state <= ST_WR;
            case (OTG_ADDR)
              REG_DATA: begin
                if (AUTOINC) r_ptr <= w_ptr_inc;
              end
              REG_MBX:  r_mbx_in <= OTG_DATA;
              REG_ADDR: r_ptr    <= OTG_DATA[ADDR_W:1];
              default:  ;
            endcase
          end
        end
        ST_RD: begin
          if (w_rd_end) begin
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
            if (AUTOINC && (r_rd_sel == REG_DATA)) r_ptr <= w_ptr_inc;
          end
        end
        ST_WR: begin
          if (OTG_WR_N) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Host write beats a same-cycle device pop.
      if (w_wr_evt && (OTG_ADDR == REG_MBX)) begin
        r_mbx_in_vld <= 1'b1;
      end else if (dev.mbx_in_pop) begin
        r_mbx_in_vld <= 1'b0;
      end

      // Device push beats a same-cycle host mailbox read end.
      if (dev.mbx_out_push) begin
        r_mbx_out  <= dev.mbx_out_data;
        r_out_full <= 1'b1;
      end else if (w_rd_end && (r_rd_sel == REG_MBX)) begin
        r_out_full <= 1'b0;
      end
    end
  end

  // DATA reads come straight from the RAM output register; others from r_dout.
  assign OTG_DATA       = r_oe ? ((r_rd_sel == REG_DATA) ? r_hpi_q : r_dout) : 16'hzzzz;
  assign OTG_INT        = r_out_full;
  assign dev.loc_ack    = r_loc_ack;
  assign dev.loc_rdata  = r_loc_ack ? r_loc_q : 16'h0000;
  assign dev.mbx_in     = r_mbx_in;
  assign dev.mbx_in_vld = r_mbx_in_vld;

endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder. Plays the host on the HPI bus and the
// device logic on the local/mailbox port; expected values go into a queue when
// stimulus is driven and are popped when the DUT answers.
module tb_hpi_responder;
  localparam int ADDR_W = 8;

`ifdef HPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire  [15:0] otg_data;
  logic [15:0] tb_dout = 16'h0000;
  logic        tb_oe = 1'b0;
  logic [1:0]  otg_addr = 2'd0;
  logic        cs_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        otg_int;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got;
  logic [15:0] exp;
  int          lat;

  always #5 clk = ~clk;

  // Host data driver; an undriven bus floats to all ones through the pullups.
  assign otg_data = tb_oe ? tb_dout : 16'hzzzz;
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (otg_data[gi]);
  end

  hpi_responder_if #(.ADDR_W(ADDR_W)) bus_if ();

  hpi_responder #(.ADDR_W(ADDR_W), .MBX_RST(16'h0000)) dut (
    .Clk      (clk),
    .Reset_N  (rst_n),
    .OTG_DATA (otg_data),
    .OTG_ADDR (otg_addr),
    .OTG_CS_N (cs_n),
    .OTG_RD_N (rd_n),
    .OTG_WR_N (wr_n),
    .OTG_INT  (otg_int),
    .dev      (bus_if)
  );

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    otg_addr = a; tb_dout = d; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    wr_n = 1'b1; cs_n = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    otg_addr = a; cs_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); @(negedge clk);
    d = otg_data;
    @(posedge clk); #1;
    rd_n = 1'b1; cs_n = 1'b1;
  endtask

  task automatic loc_access(input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] wd,
                            output logic [15:0] rd, output int cycles);
    @(posedge clk); #1;
    bus_if.loc_req = 1'b1; bus_if.loc_we = we; bus_if.loc_addr = a; bus_if.loc_wdata = wd;
    cycles = 0;
    do begin
      @(posedge clk); @(negedge clk);
      cycles++;
    end while (!bus_if.loc_ack && cycles < 20);
    rd = bus_if.loc_rdata;
    bus_if.loc_req = 1'b0; bus_if.loc_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (otg_data !== 16'hFFFF) begin n_errors++; $display("FAIL reset_bus_z: got %h expected %h", otg_data, 16'hFFFF); end
    n_checks++; if (otg_int !== 1'b0) begin n_errors++; $display("FAIL reset_int: got %b expected 0", otg_int); end
    n_checks++; if (bus_if.loc_ack !== 1'b0 || bus_if.loc_rdata !== 16'h0000) begin n_errors++; $display("FAIL reset_loc: got ack=%b rdata=%h expected ack=0 rdata=0000", bus_if.loc_ack, bus_if.loc_rdata); end
    n_checks++; if (bus_if.mbx_in !== 16'h0000 || bus_if.mbx_in_vld !== 1'b0) begin n_errors++; $display("FAIL reset_mbx_in: got %h/%b expected 0000/0", bus_if.mbx_in, bus_if.mbx_in_vld); end
    exp_q.push_back(16'h0000); host_read(A_STAT, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL reset_status: got %h expected %h", got, exp); end
    exp_q.push_back(16'h0000); host_read(A_ADDR, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL reset_address: got %h expected %h", got, exp); end
  endtask

  task automatic test_data_autoinc();
    loc_access(1'b1, 8'd9, 16'h0999, got, lat);
    n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL loc_idle_latency: got %0d expected 1", lat); end
    host_write(A_ADDR, 16'h0010);
    host_write(A_DATA, 16'hA5A5);
    host_write(A_DATA, 16'h5A5A);
    exp_q.push_back(AUTOINC ? 16'hA5A5 : 16'h5A5A);
    exp_q.push_back(AUTOINC ? 16'h5A5A : 16'h0999);
    loc_access(1'b0, 8'd8, 16'h0000, got, lat); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL word8: got %h expected %h", got, exp); end
    loc_access(1'b0, 8'd9, 16'h0000, got, lat); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL word9: got %h expected %h", got, exp); end
    exp_q.push_back(AUTOINC ? 16'h0014 : 16'h0010); host_read(A_ADDR, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL address_after_writes: got %h expected %h", got, exp); end
    host_write(A_ADDR, 16'h0010);
    exp_q.push_back(AUTOINC ? 16'hA5A5 : 16'h5A5A); host_read(A_DATA, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL host_data_read: got %h expected %h", got, exp); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (otg_data !== 16'hFFFF) begin n_errors++; $display("FAIL bus_z_after_read: got %h expected %h", otg_data, 16'hFFFF); end
    exp_q.push_back(AUTOINC ? 16'h0012 : 16'h0010); host_read(A_ADDR, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL address_after_read: got %h expected %h", got, exp); end
  endtask

  task automatic test_wrap();
    loc_access(1'b1, 8'd0,   16'h1111, got, lat);
    loc_access(1'b1, 8'd255, 16'h2222, got, lat);
    host_write(A_ADDR, 16'h01FE);
    host_write(A_DATA, 16'hC001);
    host_write(A_DATA, 16'hC002);
    exp_q.push_back(AUTOINC ? 16'hC001 : 16'hC002);
    exp_q.push_back(AUTOINC ? 16'hC002 : 16'h1111);
    exp_q.push_back(AUTOINC ? 16'h0002 : 16'h01FE);
    loc_access(1'b0, 8'd255, 16'h0000, got, lat); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL wrap_word255: got %h expected %h", got, exp); end
    loc_access(1'b0, 8'd0, 16'h0000, got, lat); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL wrap_word0: got %h expected %h", got, exp); end
    host_read(A_ADDR, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL wrap_address: got %h expected %h", got, exp); end
    // Bit 0 and bits above ADDR_W of the byte address are dropped.
    host_write(A_ADDR, 16'hFE11);
    exp_q.push_back(16'h0010); host_read(A_ADDR, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL address_mask: got %h expected %h", got, exp); end
  endtask

  task automatic test_mbx_in();
    host_write(A_MBX, 16'h1234);
    n_checks++; if (bus_if.mbx_in !== 16'h1234 || bus_if.mbx_in_vld !== 1'b1) begin n_errors++; $display("FAIL mbx_in_write: got %h/%b expected 1234/1", bus_if.mbx_in, bus_if.mbx_in_vld); end
    exp_q.push_back(16'h0001); host_read(A_STAT, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL status_in_full: got %h expected %h", got, exp); end
    @(posedge clk); #1; bus_if.mbx_in_pop = 1'b1;
    @(posedge clk); #1; bus_if.mbx_in_pop = 1'b0;
    exp_q.push_back(16'h0000); host_read(A_STAT, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL status_after_pop: got %h expected %h", got, exp); end
    host_write(A_MBX, 16'h1111);
    host_write(A_MBX, 16'h5678);
    n_checks++; if (bus_if.mbx_in !== 16'h5678 || bus_if.mbx_in_vld !== 1'b1) begin n_errors++; $display("FAIL mbx_in_overwrite: got %h/%b expected 5678/1", bus_if.mbx_in, bus_if.mbx_in_vld); end
    @(posedge clk); #1; bus_if.mbx_in_pop = 1'b1;
    @(posedge clk); #1; bus_if.mbx_in_pop = 1'b0;
    // Pop in the same cycle as a host write: the write wins.
    @(posedge clk); #1;
    otg_addr = A_MBX; tb_dout = 16'h9ABC; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0; bus_if.mbx_in_pop = 1'b1;
    @(posedge clk); #1;
    wr_n = 1'b1; cs_n = 1'b1; tb_oe = 1'b0; bus_if.mbx_in_pop = 1'b0;
    n_checks++; if (bus_if.mbx_in !== 16'h9ABC || bus_if.mbx_in_vld !== 1'b1) begin n_errors++; $display("FAIL mbx_in_pop_vs_write: got %h/%b expected 9abc/1", bus_if.mbx_in, bus_if.mbx_in_vld); end
    @(posedge clk); #1; bus_if.mbx_in_pop = 1'b1;
    @(posedge clk); #1; bus_if.mbx_in_pop = 1'b0;
    n_checks++; if (bus_if.mbx_in_vld !== 1'b0) begin n_errors++; $display("FAIL mbx_in_vld_cleared: got %b expected 0", bus_if.mbx_in_vld); end
  endtask

  task automatic test_mbx_out();
    @(posedge clk); #1; bus_if.mbx_out_data = 16'hBEEF; bus_if.mbx_out_push = 1'b1;
    @(negedge clk);
    n_checks++; if (otg_int !== 1'b0) begin n_errors++; $display("FAIL int_before_push: got %b expected 0", otg_int); end
    @(posedge clk); #1; bus_if.mbx_out_push = 1'b0;
    n_checks++; if (otg_int !== 1'b1) begin n_errors++; $display("FAIL int_after_push: got %b expected 1", otg_int); end
    exp_q.push_back(16'h0002); host_read(A_STAT, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL status_out_full: got %h expected %h", got, exp); end
    exp_q.push_back(16'hBEEF); host_read(A_MBX, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL mbx_out_read: got %h expected %h", got, exp); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (otg_int !== 1'b0) begin n_errors++; $display("FAIL int_after_read_end: got %b expected 0", otg_int); end
    // Push coincident with the read end keeps the flag and loads the new value.
    @(posedge clk); #1; bus_if.mbx_out_data = 16'hCAFE; bus_if.mbx_out_push = 1'b1;
    @(posedge clk); #1; bus_if.mbx_out_push = 1'b0;
    exp_q.push_back(16'hCAFE);
    @(posedge clk); #1; otg_addr = A_MBX; cs_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); @(negedge clk); got = otg_data; exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL mbx_out_read2: got %h expected %h", got, exp); end
    @(posedge clk); #1; rd_n = 1'b1; cs_n = 1'b1; bus_if.mbx_out_data = 16'h0BAD; bus_if.mbx_out_push = 1'b1;
    @(posedge clk); #1; bus_if.mbx_out_push = 1'b0;
    n_checks++; if (otg_int !== 1'b1) begin n_errors++; $display("FAIL int_push_vs_read_end: got %b expected 1", otg_int); end
    exp_q.push_back(16'h0BAD); host_read(A_MBX, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL mbx_out_new_value: got %h expected %h", got, exp); end
  endtask

  task automatic test_loc_contention();
    host_write(A_ADDR, 16'h0060);
    exp_q.push_back(16'hD00D);
    @(posedge clk); #1;
    otg_addr = A_DATA; tb_dout = 16'hD00D; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    bus_if.loc_req = 1'b1; bus_if.loc_we = 1'b0; bus_if.loc_addr = 8'h30;
    @(posedge clk); #1;
    wr_n = 1'b1; cs_n = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_if.loc_ack !== 1'b0) begin n_errors++; $display("FAIL loc_ack_delayed: got %b expected 0", bus_if.loc_ack); end
    @(posedge clk); @(negedge clk);
    got = bus_if.loc_rdata; exp = exp_q.pop_front();
    n_checks++; if (bus_if.loc_ack !== 1'b1 || got !== exp) begin n_errors++; $display("FAIL loc_contended_read: got ack=%b %h expected ack=1 %h", bus_if.loc_ack, got, exp); end
    bus_if.loc_req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (bus_if.loc_ack !== 1'b0) begin n_errors++; $display("FAIL loc_ack_pulse: got %b expected 0", bus_if.loc_ack); end
    exp_q.push_back(AUTOINC ? 16'h0999 : 16'h0999);
    loc_access(1'b0, 8'd9, 16'h0000, got, lat); exp = exp_q.pop_front();
    n_checks++; if (got !== exp && !AUTOINC) begin n_errors++; $display("FAIL word9_untouched: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid_read();
    loc_access(1'b1, 8'h20, 16'h7E57, got, lat);
    host_write(A_MBX, 16'h4321);
    @(posedge clk); #1; bus_if.mbx_out_data = 16'h1357; bus_if.mbx_out_push = 1'b1;
    @(posedge clk); #1; bus_if.mbx_out_push = 1'b0;
    host_write(A_ADDR, 16'h0040);
    exp_q.push_back(16'h7E57);
    @(posedge clk); #1; otg_addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); @(negedge clk); got = otg_data; exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL read_before_reset: got %h expected %h", got, exp); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (otg_data !== 16'hFFFF) begin n_errors++; $display("FAIL bus_z_on_reset: got %h expected %h", otg_data, 16'hFFFF); end
    cs_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'h0000); host_read(A_STAT, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL status_after_reset: got %h expected %h", got, exp); end
    exp_q.push_back(16'h0000); host_read(A_ADDR, got); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL address_after_reset: got %h expected %h", got, exp); end
    exp_q.push_back(16'h7E57);
    loc_access(1'b0, 8'h20, 16'h0000, got, lat); exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ram_kept_over_reset: got %h expected %h", got, exp); end
  endtask

  initial begin
    bus_if.loc_addr     = '0;
    bus_if.loc_req      = 1'b0;
    bus_if.loc_we       = 1'b0;
    bus_if.loc_wdata    = 16'h0000;
    bus_if.mbx_in_pop   = 1'b0;
    bus_if.mbx_out_data = 16'h0000;
    bus_if.mbx_out_push = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_data_autoinc();
    test_wrap();
    test_mbx_in();
    test_mbx_out();
    test_loc_contention();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end
endmodule
